// File: rtl/fir_pkg.sv
// Shared types and helpers for the time-multiplexed FIR filter.
package fir_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    OUT
  } fir_state_e;

  function automatic int acc_width(input int data_w, input int coef_w, input int taps);
    return data_w + coef_w + $clog2(taps);
  endfunction

  function automatic int default_coef(input int k);
    return k + 1;
  endfunction

endpackage

// File: rtl/fir_mac_unit.sv
// Registered signed multiply-accumulate: clear has priority over enable.
module fir_mac_unit #(
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  parameter int ACC_W  = 19
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     enable,
  input  logic signed [DATA_W-1:0] sample,
  input  logic signed [COEF_W-1:0] coef,
  output logic signed [ACC_W-1:0]  acc
);

  localparam int PROD_W = DATA_W + COEF_W;

  logic signed [PROD_W-1:0] product;
  logic signed [ACC_W-1:0]  product_ext;

  assign product     = sample * coef;
  assign product_ext = ACC_W'(product);

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      acc <= '0;
    end else if (enable) begin
      acc <= acc + product_ext;
    end
  end

endmodule

// File: rtl/fir_mac_filter.sv
// Time-multiplexed FIR filter sharing one MAC across TAPS cycles per sample.
// Define FIR_SAT_EN to clamp (instead of wrap) when OUT_W < ACC_W.
module fir_mac_filter
  import fir_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  parameter int TAPS   = 8,
  parameter int ACC_W  = acc_width(DATA_W, COEF_W, TAPS),
  parameter int OUT_W  = ACC_W
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic signed [DATA_W-1:0]   in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic signed [OUT_W-1:0]    out_data,
  output logic                       out_sat,
  input  logic                       coef_we,
  input  logic [$clog2(TAPS)-1:0]    coef_addr,
  input  logic signed [COEF_W-1:0]   coef_data
);

  localparam int IDX_W = $clog2(TAPS);

  fir_state_e state, next_state;

  logic signed [DATA_W-1:0] x    [TAPS];
  logic signed [COEF_W-1:0] coef [TAPS];
  logic [IDX_W-1:0]         idx;
  logic                     accept;
  logic                     mac_clear;
  logic                     mac_en;
  logic signed [ACC_W-1:0]  acc;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    mac_clear  = 1'b0;
    mac_en     = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          next_state = MAC;
          mac_clear  = 1'b1;
        end
      end
      MAC: begin
        mac_en = 1'b1;
        if (idx == IDX_W'(TAPS - 1)) begin
          next_state = OUT;
        end
      end
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  assign accept = in_valid && in_ready;

  // Coefficient writes only land in IDLE, so a running MAC never sees a half-updated set.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < TAPS; k++) begin
        x[k]    <= '0;
        coef[k] <= COEF_W'(default_coef(k));
      end
      idx <= '0;
    end else begin
      if (state == IDLE && coef_we && int'(coef_addr) < TAPS) begin
        coef[coef_addr] <= coef_data;
      end
      if (accept) begin
        x[0] <= in_data;
        for (int k = 1; k < TAPS; k++) begin
          x[k] <= x[k-1];
        end
        idx <= '0;
      end else if (state == MAC) begin
        idx <= idx + 1'b1;
      end
    end
  end

  fir_mac_unit #(
    .DATA_W (DATA_W),
    .COEF_W (COEF_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .clock  (clock),
    .reset  (reset),
    .clear  (mac_clear),
    .enable (mac_en),
    .sample (x[idx]),
    .coef   (coef[idx]),
    .acc    (acc)
  );

`ifdef FIR_SAT_EN
  if (OUT_W < ACC_W) begin : g_sat
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

    always_comb begin
      out_data = acc[OUT_W-1:0];
      out_sat  = 1'b0;
      if (acc > SAT_MAX) begin
        out_data = SAT_MAX[OUT_W-1:0];
        out_sat  = 1'b1;
      end else if (acc < SAT_MIN) begin
        out_data = SAT_MIN[OUT_W-1:0];
        out_sat  = 1'b1;
      end
    end
  end else begin : g_full
    assign out_data = acc[OUT_W-1:0];
    assign out_sat  = 1'b0;
  end
`else
  assign out_data = acc[OUT_W-1:0];
  assign out_sat  = 1'b0;
`endif

endmodule

// File: tb/tb_fir_mac_filter.sv
// Scoreboard bench for fir_mac_filter: a full-width instance and an 8-bit narrowed instance
// driven in lockstep and checked against a direct convolution model of the filter.
module tb_fir_mac_filter;

  localparam int TAPS     = 8;
  localparam int DATA_W   = 8;
  localparam int COEF_W   = 8;
  localparam int ACC_W    = DATA_W + COEF_W + $clog2(TAPS);
  localparam int NARROW_W = 8;

  logic clock = 1'b0;
  logic reset;
  logic in_valid;
  logic signed [DATA_W-1:0] in_data;
  logic out_ready;
  logic coef_we;
  logic [2:0] coef_addr;
  logic signed [COEF_W-1:0] coef_data;

  logic in_ready, out_valid, out_sat;
  logic signed [ACC_W-1:0] out_data;
  logic n_in_ready, n_out_valid, n_out_sat;
  logic signed [NARROW_W-1:0] n_out_data;

  always #5 clock = ~clock;

  fir_mac_filter #(.DATA_W(DATA_W), .COEF_W(COEF_W), .TAPS(TAPS)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_sat(out_sat),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data)
  );

  fir_mac_filter #(.DATA_W(DATA_W), .COEF_W(COEF_W), .TAPS(TAPS), .OUT_W(NARROW_W)) dut_n (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(n_in_ready), .in_data(in_data),
    .out_valid(n_out_valid), .out_ready(out_ready), .out_data(n_out_data), .out_sat(n_out_sat),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data)
  );

  typedef struct {
    longint sum;
    longint accept_cycle;
  } exp_t;

  exp_t exp_q[$];
  int errors = 0;
  int checks = 0;
  longint cycle = 0;
  logic signed [DATA_W-1:0] hist   [TAPS];
  logic signed [COEF_W-1:0] coef_m [TAPS];
  bit hold_low = 1'b0;
  bit random_ready = 1'b0;

  always @(posedge clock) cycle <= cycle + 1;

  task automatic checkOutput(input string name, input logic signed [63:0] act,
                             input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic report_fail(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: bound expired, required event never happened (t=%0t)", name, $time);
  endtask

  function automatic longint narrow_exp(input longint s);
`ifdef FIR_SAT_EN
    longint mx = (64'sd1 <<< (NARROW_W - 1)) - 1;
    if (s > mx) return mx;
    if (s < -mx - 1) return -mx - 1;
    return s;
`else
    longint t = s <<< (64 - NARROW_W);
    return t >>> (64 - NARROW_W);
`endif
  endfunction

  function automatic longint narrow_sat(input longint s);
`ifdef FIR_SAT_EN
    longint mx = (64'sd1 <<< (NARROW_W - 1)) - 1;
    return (s > mx || s < -mx - 1) ? 1 : 0;
`else
    return (s != s) ? 1 : 0;
`endif
  endfunction

  task automatic model_reset();
    for (int k = 0; k < TAPS; k++) begin
      hist[k]   = '0;
      coef_m[k] = COEF_W'(k + 1);
    end
  endtask

  task automatic model_accept(input logic signed [DATA_W-1:0] d);
    longint s = 0;
    for (int k = TAPS - 1; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = d;
    for (int k = 0; k < TAPS; k++) s += longint'(hist[k]) * longint'(coef_m[k]);
    exp_q.push_back('{sum: s, accept_cycle: cycle});
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Offer one sample (optionally with a coefficient write in the same cycle) until accepted.
  task automatic applyStimulus(input logic signed [DATA_W-1:0] d, input bit we = 1'b0,
                               input int addr = 0, input logic signed [COEF_W-1:0] cd = '0);
    int budget = 0;
    bit ok = 1'b0;
    in_valid  = 1'b1;
    in_data   = d;
    coef_we   = we;
    coef_addr = 3'(addr);
    coef_data = cd;
    forever begin
      ok = in_ready;
      tick();
      if (ok) break;
      budget++;
      if (budget > 200) begin
        report_fail("accept_timeout");
        break;
      end
    end
    in_valid = 1'b0;
    coef_we  = 1'b0;
    if (ok) begin
      if (we) coef_m[addr] = cd;
      model_accept(d);
    end
  endtask

  task automatic drain();
    int budget = 0;
    while (exp_q.size() != 0) begin
      tick();
      budget++;
      if (budget > 500) begin
        report_fail("drain_timeout");
        exp_q.delete();
        break;
      end
    end
  endtask

  task automatic write_coef(input int addr, input logic signed [COEF_W-1:0] val);
    coef_we   = 1'b1;
    coef_addr = 3'(addr);
    coef_data = val;
    tick();
    coef_we = 1'b0;
    coef_m[addr] = val;
  endtask

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clock);
      #1;
      out_ready = hold_low ? 1'b0 : (random_ready ? ($urandom_range(0, 3) != 0) : 1'b1);
    end
  end

  // Monitor: every cycle an output is presented it must match the scoreboard head.
  logic prev_valid = 1'b0;
  logic prev_xfer  = 1'b0;
  always @(negedge clock) begin
    if (reset) begin
      prev_valid <= 1'b0;
      prev_xfer  <= 1'b0;
    end else begin
      if (prev_xfer) checkOutput("valid_drop", out_valid, 0);
      if (out_valid) begin
        checkOutput("in_ready_busy", in_ready, 0);
        checkOutput("narrow_valid", n_out_valid, 1);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_output: got out_valid=1, expected no pending result");
        end else begin
          if (!prev_valid) checkOutput("latency", cycle - exp_q[0].accept_cycle, TAPS);
          checkOutput("out_data", out_data, exp_q[0].sum);
          checkOutput("out_sat", out_sat, 0);
          checkOutput("narrow_data", n_out_data, narrow_exp(exp_q[0].sum));
          checkOutput("narrow_sat", n_out_sat, narrow_sat(exp_q[0].sum));
          if (out_ready) void'(exp_q.pop_front());
        end
      end
      prev_valid <= out_valid;
      prev_xfer  <= out_valid && out_ready;
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int budget;
    logic signed [DATA_W-1:0] rd;
    logic signed [COEF_W-1:0] rc;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    coef_we   = 1'b0;
    coef_addr = '0;
    coef_data = '0;
    model_reset();
    repeat (2) tick();
    checkOutput("reset_in_ready", in_ready, 1);
    checkOutput("reset_out_valid", out_valid, 0);
    checkOutput("reset_out_data", out_data, 0);
    checkOutput("reset_out_sat", out_sat, 0);
    checkOutput("reset_narrow_valid", n_out_valid, 0);
    checkOutput("reset_narrow_data", n_out_data, 0);
    reset = 1'b0;

    $display("[TB] impulse and step with default coefficients");
    applyStimulus(1);
    repeat (8) applyStimulus(0);
    repeat (9) applyStimulus(1);
    drain();

    $display("[TB] backpressure");
    hold_low = 1'b1;
    applyStimulus(7);
    budget = 0;
    while (!out_valid && budget < 50) begin
      tick();
      budget++;
    end
    if (!out_valid) report_fail("out_valid_timeout");
    repeat (5) tick();
    hold_low = 1'b0;
    drain();

    $display("[TB] coefficient load, ignored write during MAC, narrowing");
    write_coef(0, -3);
    for (int k = 1; k < TAPS; k++) write_coef(k, 0);
    applyStimulus(5);
    tick();
    coef_we   = 1'b1;
    coef_addr = 3'd0;
    coef_data = 8'sd50;
    tick();
    coef_we = 1'b0;
    drain();
    applyStimulus(2);
    drain();
    write_coef(0, 127);
    applyStimulus(127);
    applyStimulus(-128);
    applyStimulus(10, 1'b1, 0, -7);
    drain();

    $display("[TB] reset during MAC");
    applyStimulus(9);
    repeat (3) tick();
    reset = 1'b1;
    exp_q.delete();
    model_reset();
    tick();
    checkOutput("midreset_out_valid", out_valid, 0);
    checkOutput("midreset_in_ready", in_ready, 1);
    checkOutput("midreset_out_data", out_data, 0);
    reset = 1'b0;
    applyStimulus(1);
    repeat (8) applyStimulus(0);
    drain();

    $display("[TB] randomized traffic");
    random_ready = 1'b1;
    for (int i = 0; i < 60; i++) begin
      rd = DATA_W'($urandom);
      rc = COEF_W'($urandom);
      case ($urandom_range(0, 3))
        0: begin
          drain();
          write_coef(int'($urandom_range(0, TAPS - 1)), rc);
        end
        1: applyStimulus(rd, 1'b1, int'($urandom_range(0, TAPS - 1)), rc);
        default: applyStimulus(rd);
      endcase
    end
    drain();
    random_ready = 1'b0;
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
